dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (D_mem) between two requesters:
//   - the pipeline MEM stage (CPU port, driven from MemRead_m/MemWrite_m/address/data_m);
//   - a DMA/loader port.
//  Sequences multi-cycle memory accesses and stalls the pipeline (freeze IF..MEM) while the CPU access is not complete.
//  Sits between ex_mem/mem_wb and D_mem. cpu_stall is ORed into the pipeline-freeze path.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  MEM_LAT     1   memory cycles per access (1..4); access completes in its MEM_LAT-th cycle
//  STARVE_MAX  2   consecutive CPU grants while DMA waits before DMA wins a tie (>=1)
//  CNT_W       16  width of the conflict_cnt performance counter
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous reset, active-low
//  cpu_rd        in   1       MEM-stage read request
//  cpu_wr        in   1       MEM-stage write request (wins if cpu_rd also high)
//  cpu_addr      in   ADDR_W  CPU address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_rdata     out  DATA_W  read data, valid in CPU completion cycle
//  cpu_stall     out  1       freeze pipeline this cycle
//  dma_req       in   1       DMA request; held with dma_we/addr/wdata stable until dma_ack
//  dma_we        in   1       1=write, 0=read
//  dma_addr      in   ADDR_W  DMA address
//  dma_wdata     in   DATA_W  DMA write data
//  dma_ack       out  1       one-cycle pulse in DMA completion cycle
//  dma_rdata     out  DATA_W  read data, valid with dma_ack
//  mem_addr      out  ADDR_W  to D_mem address
//  mem_wdata     out  DATA_W  to D_mem data
//  mem_rd        out  1       to D_mem memRead
//  mem_wr        out  1       to D_mem memWrite
//  mem_rdata     in   DATA_W  from D_mem mem_data
//  conflict_cnt  out  CNT_W   saturating count of cycles CPU stalled while DMA owns memory
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; lat_cnt=0; starve_cnt=0; conflict_cnt=0.
//   - mem_rd, mem_wr, cpu_stall and dma_ack are forced 0 immediately.
//   - An access in flight is aborted with no ack or completion.
//   - mem_addr, mem_wdata, cpu_rdata and dma_rdata read 0.
//  FSM states:
//   - IDLE: no access open.
//   - CPU_ACC: CPU owns memory.
//   - DMA_ACC: DMA owns memory.
//   - lat_cnt counts the cycles of the open access.
//  Arbitration (IDLE only, combinational):
//   - Only CPU requesting (cpu_rd|cpu_wr): CPU is granted.
//   - Only dma_req: DMA is granted.
//   - Both requesting: CPU is granted unless starve_cnt==STARVE_MAX, in which case DMA is granted.
//  Access timing:
//   - An access starts in its grant cycle. mem_* are driven from the owner's live inputs.
//   - MEM_LAT=1: the access completes in the grant cycle and the state stays IDLE.
//   - MEM_LAT>1: the FSM goes to the owner state with lat_cnt=1. lat_cnt increments each cycle.
//   - Completion is at lat_cnt==MEM_LAT-1, then the FSM returns to IDLE. No bubble: the next grant can occur in the following cycle.
//  Memory strobes:
//   - mem_rd = owner reads; mem_wr = owner writes.
//   - Strobes are held every cycle of the access and are 0 with no owner.
//  cpu_stall: (cpu_rd|cpu_wr) & ~(CPU owns memory & completion cycle).
//  cpu_rdata:
//   - Equals mem_rdata in the CPU completion cycle; otherwise it holds its last value.
//   - It is registered on completion for hold, with a combinational bypass in the completion cycle.
//  dma_ack: 1 only in the DMA completion cycle. dma_rdata=mem_rdata in that cycle and is then held.
//  dma_req handling: the DMA may keep dma_req high after dma_ack to issue a new request; it is re-arbitrated in the next cycle.
//  starve_cnt:
//   - +1 on each CPU grant while dma_req=1 (saturates at STARVE_MAX).
//   - Cleared on DMA grant and when dma_req=0 in IDLE.
//  conflict_cnt: +1 each cycle with cpu_stall=1 and state==DMA_ACC; saturates at all-ones.
//  Input rule: owner inputs that change mid-access are undefined; the CPU is held by cpu_stall.
// TESTING
//  1. MEM_LAT=1, cpu_rd=1 addr=0x10, mem_rdata=0xCAFE, no DMA -> mem_rd=1 same cycle, cpu_stall=0, cpu_rdata=0xCAFE.
//  2. MEM_LAT=3, cpu_wr addr=0x20 data=0x55 -> mem_wr=1 for 3 cycles, cpu_stall=1,1,0.
//  3. MEM_LAT=1, STARVE_MAX=2, cpu_rd every cycle + dma_req -> CPU cycles 0-1; cycle 2 dma_ack=1, cpu_stall=1; CPU cycle 3.
//  4. MEM_LAT=3, DMA read granted at t0, cpu_rd at t1 -> cpu_stall t1..t4, dma_ack t2, CPU completes t5, conflict_cnt=2.
//  5. reset=0 at 2nd cycle of DMA write -> mem_wr=0 at once, no dma_ack, all counters 0, IDLE after release.
//  6. CNT_W=4, 20 DMA-conflict stall cycles -> conflict_cnt sticks at 0xF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (CPU)
// and a DMA/loader port. Opens one multi-cycle access at a time, drives the
// memory strobes from the current owner, and stalls the pipeline until the
// CPU access completes.
//
// Ports
//   clk, reset                       clock (rising edge), async active-low reset
//   cpu_rd, cpu_wr, cpu_addr,        MEM-stage request (write wins over read)
//   cpu_wdata
//   cpu_rdata, cpu_stall             read data (valid in completion cycle), freeze
//   dma_req, dma_we, dma_addr,       DMA request, held stable until dma_ack
//   dma_wdata
//   dma_ack, dma_rdata               completion pulse and read data
//   mem_addr, mem_wdata, mem_rd,     data memory interface
//   mem_wr, mem_rdata
//   conflict_cnt                     saturating count of CPU stall cycles
//                                    spent waiting on a DMA access
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | no access open; arbitration happens here
// CPU_ACC | CPU owns memory for cycles 2..MEM_LAT
// DMA_ACC | DMA owns memory for cycles 2..MEM_LAT

module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [2:0]    LAT_LAST   = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        lat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic cpu_req;
    logic grant_cpu;
    logic grant_dma;
    logic own_cpu;
    logic own_dma;
    logic last_cycle;
    logic cpu_done;
    logic dma_done;

    always_comb begin
        cpu_req   = cpu_rd | cpu_wr;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        // Grants are suppressed during reset so the strobes drop immediately.
        if (reset && state == IDLE) begin
            if (cpu_req && !(dma_req && starve_cnt == STARVE_TOP)) begin
                grant_cpu = 1'b1;
            end else if (dma_req) begin
                grant_dma = 1'b1;
            end
        end

        own_cpu = reset & (grant_cpu | (state == CPU_ACC));
        own_dma = reset & (grant_dma | (state == DMA_ACC));

        // Single-cycle memory completes in the grant cycle without leaving IDLE.
        if (MEM_LAT == 1) begin
            last_cycle = 1'b1;
        end else begin
            last_cycle = (state != IDLE) && (lat_cnt == LAT_LAST);
        end

        cpu_done = own_cpu & last_cycle;
        dma_done = own_dma & last_cycle;

        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (own_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wr    = cpu_wr;
            mem_rd    = cpu_rd & ~cpu_wr;
        end else if (own_dma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_wr    = dma_we;
            mem_rd    = ~dma_we;
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_done;
    assign dma_ack   = dma_done;
    // Bypass makes read data usable in the completion cycle; the register holds it.
    assign cpu_rdata = cpu_done ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = dma_done ? mem_rdata : dma_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_cnt      <= 3'd0;
            starve_cnt   <= '0;
            conflict_cnt <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_LAT > 1) begin
                        if (grant_cpu) begin
                            state   <= CPU_ACC;
                            lat_cnt <= 3'd1;
                        end else if (grant_dma) begin
                            state   <= DMA_ACC;
                            lat_cnt <= 3'd1;
                        end
                    end
                end
                CPU_ACC, DMA_ACC: begin
                    if (lat_cnt == LAT_LAST) begin
                        state   <= IDLE;
                        lat_cnt <= 3'd0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    lat_cnt <= 3'd0;
                end
            endcase

            if (state == IDLE) begin
                if (grant_dma) begin
                    starve_cnt <= '0;
                end else if (grant_cpu && dma_req) begin
                    if (starve_cnt != STARVE_TOP) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end else if (!dma_req) begin
                    starve_cnt <= '0;
                end
            end

            if (cpu_stall && state == DMA_ACC && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end

            if (cpu_done) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dma_done) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances share the stimulus. u1 has single-cycle
// memory (MEM_LAT=1, 16-bit counter); u3 has three-cycle memory with a 4-bit
// counter. Each test looks at the instance it targets.

module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
    logic        cpu_stall1, dma_ack1, mem_rd1, mem_wr1;
    logic [15:0] conflict1;

    logic [31:0] cpu_rdata3, dma_rdata3, mem_addr3, mem_wdata3;
    logic        cpu_stall3, dma_ack3, mem_rd3, mem_wr3;
    logic [3:0]  conflict3;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack1), .dma_rdata(dma_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict1)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(2), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack3), .dma_rdata(dma_rdata3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rd(mem_rd3), .mem_wr(mem_wr3),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: who holds memory, how many cycles of the access
    // have elapsed, and the bookkeeping counters.
    int          m_owner;   // 0 none, 1 cpu, 2 dma
    int          m_elapsed;
    int          m_starve;
    int          m_conflict;
    logic [31:0] m_cpu_rdata;
    logic [31:0] m_dma_rdata;

    task automatic clear_inputs();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        m_owner = 0; m_elapsed = 0; m_starve = 0; m_conflict = 0;
        m_cpu_rdata = 0; m_dma_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        cpu_rd = 1; cpu_addr = 32'h123; dma_req = 1; dma_addr = 32'h456;
        mem_rdata = 32'hFFFF_FFFF;
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({mem_rd1, mem_wr1, cpu_stall1, dma_ack1} !== 4'b0) begin
                errors++; $display("FAIL reset_strobes1: got %b expected 0000", {mem_rd1, mem_wr1, cpu_stall1, dma_ack1});
            end
            checks++;
            if ({mem_rd3, mem_wr3, cpu_stall3, dma_ack3} !== 4'b0) begin
                errors++; $display("FAIL reset_strobes3: got %b expected 0000", {mem_rd3, mem_wr3, cpu_stall3, dma_ack3});
            end
            checks++;
            if (mem_addr1 !== 0 || cpu_rdata1 !== 0 || dma_rdata3 !== 0 || mem_addr3 !== 0) begin
                errors++; $display("FAIL reset_data: got addr1=%h rd1=%h drd3=%h addr3=%h expected 0", mem_addr1, cpu_rdata1, dma_rdata3, mem_addr3);
            end
            checks++;
            if (conflict1 !== 0 || conflict3 !== 0) begin
                errors++; $display("FAIL reset_conflict: got %0d/%0d expected 0", conflict1, conflict3);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_single_read();
        do_reset();
        cpu_rd = 1; cpu_addr = 32'h10; mem_rdata = 32'hCAFE;
        @(negedge clk);
        checks++;
        if (mem_rd1 !== 1 || mem_addr1 !== 32'h10) begin
            errors++; $display("FAIL t1_strobe: got rd=%b addr=%h expected rd=1 addr=10", mem_rd1, mem_addr1);
        end
        checks++;
        if (cpu_stall1 !== 0) begin
            errors++; $display("FAIL t1_stall: got %b expected 0", cpu_stall1);
        end
        checks++;
        if (cpu_rdata1 !== 32'hCAFE) begin
            errors++; $display("FAIL t1_rdata: got %h expected cafe", cpu_rdata1);
        end
        step();
        cpu_rd = 0; mem_rdata = 32'h1111;
        @(negedge clk);
        checks++;
        if (cpu_rdata1 !== 32'hCAFE || mem_rd1 !== 0) begin
            errors++; $display("FAIL t1_hold: got rdata=%h rd=%b expected cafe 0", cpu_rdata1, mem_rd1);
        end
        step();
    endtask

    task automatic test_slow_write();
        do_reset();
        cpu_wr = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (mem_wr3 !== 1 || mem_rd3 !== 0 || mem_addr3 !== 32'h20 || mem_wdata3 !== 32'h55) begin
                errors++; $display("FAIL t2_strobe c%0d: got wr=%b rd=%b addr=%h data=%h expected 1 0 20 55", t, mem_wr3, mem_rd3, mem_addr3, mem_wdata3);
            end
            checks++;
            if (cpu_stall3 !== (t < 2)) begin
                errors++; $display("FAIL t2_stall c%0d: got %b expected %b", t, cpu_stall3, (t < 2));
            end
            step();
        end
        cpu_wr = 0;
        @(negedge clk);
        checks++;
        if (mem_wr3 !== 0 || cpu_stall3 !== 0) begin
            errors++; $display("FAIL t2_after: got wr=%b stall=%b expected 0 0", mem_wr3, cpu_stall3);
        end
        step();
    endtask

    task automatic test_starvation();
        do_reset();
        dma_req = 1; dma_we = 0; dma_addr = 32'h300;
        for (int t = 0; t < 6; t++) begin
            logic ack_exp;
            logic [31:0] addr_exp;
            cpu_rd = 1; cpu_addr = 32'h100 + t; mem_rdata = 32'hB000 + t;
            ack_exp = (t == 2) || (t == 5);
            addr_exp = ack_exp ? 32'h300 : 32'h100 + t;
            @(negedge clk);
            checks++;
            if (dma_ack1 !== ack_exp || cpu_stall1 !== ack_exp) begin
                errors++; $display("FAIL t3_grant c%0d: got ack=%b stall=%b expected %b %b", t, dma_ack1, cpu_stall1, ack_exp, ack_exp);
            end
            checks++;
            if (mem_addr1 !== addr_exp) begin
                errors++; $display("FAIL t3_addr c%0d: got %h expected %h", t, mem_addr1, addr_exp);
            end
            if (ack_exp) begin
                checks++;
                if (dma_rdata1 !== 32'hB000 + t) begin
                    errors++; $display("FAIL t3_dma_rdata c%0d: got %h expected %h", t, dma_rdata1, 32'hB000 + t);
                end
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_dma_conflict();
        logic stall_exp [6] = '{0, 1, 1, 1, 1, 0};
        logic ack_exp   [6] = '{0, 0, 1, 0, 0, 0};
        do_reset();
        for (int t = 0; t < 6; t++) begin
            dma_req = (t <= 2); dma_we = 0; dma_addr = 32'h40;
            cpu_rd = (t >= 1); cpu_addr = 32'h44;
            mem_rdata = 32'hA000 + t;
            @(negedge clk);
            checks++;
            if (cpu_stall3 !== stall_exp[t] || dma_ack3 !== ack_exp[t]) begin
                errors++; $display("FAIL t4_seq c%0d: got stall=%b ack=%b expected %b %b", t, cpu_stall3, dma_ack3, stall_exp[t], ack_exp[t]);
            end
            if (t >= 2) begin
                checks++;
                if (dma_rdata3 !== 32'hA002) begin
                    errors++; $display("FAIL t4_dma_rdata c%0d: got %h expected a002", t, dma_rdata3);
                end
            end
            if (t == 5) begin
                checks++;
                if (cpu_rdata3 !== 32'hA005 || mem_rd3 !== 1 || mem_addr3 !== 32'h44) begin
                    errors++; $display("FAIL t4_cpu_done: got rdata=%h rd=%b addr=%h expected a005 1 44", cpu_rdata3, mem_rd3, mem_addr3);
                end
            end
            step();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (conflict3 !== 4'd2) begin
            errors++; $display("FAIL t4_conflict: got %0d expected 2", conflict3);
        end
        step();
    endtask

    // Runs straight after test_dma_conflict so the counter starts non-zero.
    task automatic test_reset_abort();
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h77;
        @(negedge clk);
        checks++;
        if (mem_wr3 !== 1 || dma_ack3 !== 0) begin
            errors++; $display("FAIL t5_start: got wr=%b ack=%b expected 1 0", mem_wr3, dma_ack3);
        end
        step();
        #2;
        checks++;
        if (mem_wr3 !== 1) begin
            errors++; $display("FAIL t5_second: got wr=%b expected 1", mem_wr3);
        end
        reset = 0;
        #1;
        checks++;
        if (mem_wr3 !== 0 || dma_ack3 !== 0 || mem_addr3 !== 0) begin
            errors++; $display("FAIL t5_abort: got wr=%b ack=%b addr=%h expected 0 0 0", mem_wr3, dma_ack3, mem_addr3);
        end
        checks++;
        if (conflict3 !== 0) begin
            errors++; $display("FAIL t5_counter: got %0d expected 0", conflict3);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (dma_ack3 !== 0 || mem_wr3 !== 0) begin
                errors++; $display("FAIL t5_quiet c%0d: got ack=%b wr=%b expected 0 0", t, dma_ack3, mem_wr3);
            end
            step();
        end
        cpu_rd = 1; cpu_addr = 32'h90;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (cpu_stall3 !== (t < 2)) begin
                errors++; $display("FAIL t5_idle c%0d: got stall=%b expected %b", t, cpu_stall3, (t < 2));
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_conflict_sat();
        do_reset();
        for (int r = 1; r <= 10; r++) begin
            int want;
            for (int t = 0; t < 6; t++) begin
                dma_req = (t <= 2); dma_we = 0; dma_addr = 32'h500 + r;
                cpu_rd = (t >= 1); cpu_addr = 32'h600 + r;
                step();
            end
            clear_inputs();
            want = (2 * r > 15) ? 15 : 2 * r;
            @(negedge clk);
            checks++;
            if (int'(conflict3) !== want) begin
                errors++; $display("FAIL t6_sat round%0d: got %0d expected %0d", r, conflict3, want);
            end
            step();
        end
    endtask

    // Random traffic against the reference model; sel 0 -> u1, 1 -> u3.
    task automatic test_random(input int sel, input int cycles);
        int lat, cnt_max, starve_max;
        logic cpu_pend, dma_pend;
        lat = (sel == 0) ? 1 : 3;
        cnt_max = (sel == 0) ? 65535 : 15;
        starve_max = 2;
        do_reset();
        cpu_pend = 0; dma_pend = 0;
        for (int c = 0; c < cycles; c++) begin
            int own, idx;
            logic done, req, e_rd, e_wr, e_stall, e_ack;
            logic [31:0] e_addr, e_cpu_rdata, e_dma_rdata;
            logic a_rd, a_wr, a_stall, a_ack;
            logic [31:0] a_addr, a_wdata, a_cpu_rdata, a_dma_rdata;
            int a_conf;

            if (!cpu_pend) begin
                int r = $urandom_range(0, 3);
                cpu_rd = (r == 1) || (r == 3);
                cpu_wr = (r == 2) || (r == 3);
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (!dma_pend) begin
                dma_req = ($urandom_range(0, 2) != 0);
                dma_we = $urandom_range(0, 1);
                dma_addr = $urandom; dma_wdata = $urandom;
            end
            mem_rdata = $urandom;

            @(negedge clk);
            req = cpu_rd | cpu_wr;
            own = m_owner;
            if (own == 0) begin
                if (req && !(dma_req && m_starve == starve_max)) own = 1;
                else if (dma_req) own = 2;
                idx = 1;
            end else begin
                idx = m_elapsed + 1;
            end
            done = (own != 0) && (idx == lat);
            e_rd = (own == 1) ? (cpu_rd && !cpu_wr) : (own == 2) ? !dma_we : 1'b0;
            e_wr = (own == 1) ? cpu_wr : (own == 2) ? dma_we : 1'b0;
            e_addr = (own == 1) ? cpu_addr : dma_addr;
            e_stall = req && !(own == 1 && done);
            e_ack = (own == 2) && done;
            e_cpu_rdata = (own == 1 && done) ? mem_rdata : m_cpu_rdata;
            e_dma_rdata = e_ack ? mem_rdata : m_dma_rdata;

            a_rd = sel ? mem_rd3 : mem_rd1;
            a_wr = sel ? mem_wr3 : mem_wr1;
            a_stall = sel ? cpu_stall3 : cpu_stall1;
            a_ack = sel ? dma_ack3 : dma_ack1;
            a_addr = sel ? mem_addr3 : mem_addr1;
            a_wdata = sel ? mem_wdata3 : mem_wdata1;
            a_cpu_rdata = sel ? cpu_rdata3 : cpu_rdata1;
            a_dma_rdata = sel ? dma_rdata3 : dma_rdata1;
            a_conf = sel ? int'(conflict3) : int'(conflict1);

            checks++;
            if (a_rd !== e_rd || a_wr !== e_wr) begin
                errors++; $display("FAIL rnd%0d_strobes c%0d: got rd=%b wr=%b expected %b %b", sel, c, a_rd, a_wr, e_rd, e_wr);
            end
            if (own != 0) begin
                checks++;
                if (a_addr !== e_addr) begin
                    errors++; $display("FAIL rnd%0d_addr c%0d: got %h expected %h", sel, c, a_addr, e_addr);
                end
            end
            if (e_wr) begin
                checks++;
                if (a_wdata !== ((own == 1) ? cpu_wdata : dma_wdata)) begin
                    errors++; $display("FAIL rnd%0d_wdata c%0d: got %h expected %h", sel, c, a_wdata, (own == 1) ? cpu_wdata : dma_wdata);
                end
            end
            checks++;
            if (a_stall !== e_stall || a_ack !== e_ack) begin
                errors++; $display("FAIL rnd%0d_handshake c%0d: got stall=%b ack=%b expected %b %b", sel, c, a_stall, a_ack, e_stall, e_ack);
            end
            checks++;
            if (a_cpu_rdata !== e_cpu_rdata || a_dma_rdata !== e_dma_rdata) begin
                errors++; $display("FAIL rnd%0d_rdata c%0d: got %h/%h expected %h/%h", sel, c, a_cpu_rdata, a_dma_rdata, e_cpu_rdata, e_dma_rdata);
            end
            checks++;
            if (a_conf !== m_conflict) begin
                errors++; $display("FAIL rnd%0d_conflict c%0d: got %0d expected %0d", sel, c, a_conf, m_conflict);
            end

            if (m_owner == 0) begin
                if (own == 2) m_starve = 0;
                else if (own == 1 && dma_req) m_starve = (m_starve < starve_max) ? m_starve + 1 : starve_max;
                else if (!dma_req) m_starve = 0;
            end
            if (e_stall && m_owner == 2 && m_conflict < cnt_max) m_conflict++;
            m_cpu_rdata = e_cpu_rdata;
            m_dma_rdata = e_dma_rdata;
            m_owner = done ? 0 : own;
            m_elapsed = done ? 0 : idx;

            cpu_pend = e_stall;
            dma_pend = dma_req && !e_ack;
            step();
        end
        clear_inputs();
        step();
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_slow_write();
        test_starvation();
        test_dma_conflict();
        test_reset_abort();
        test_conflict_sat();
        test_random(0, 400);
        test_random(1, 400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
